// File: rtl/n_stream_demuxer.sv
// Single-register stream demultiplexer: one input stream steered to one of N_CH outputs.
// Optional round-robin destination pointer enabled by `define N_STREAM_DEMUXER_RR_EN.
module n_stream_demuxer #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int S    = 2
) (
    input  logic            clock,
    input  logic            reset_,
`ifdef N_STREAM_DEMUXER_RR_EN
    input  logic            rr_mode,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [S-1:0]    in_sel,
    output logic [N_CH-1:0] out_valid,
    input  logic [N_CH-1:0] out_ready,
    output logic [W-1:0]    out_data,
    output logic            busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   data_q;
    logic [S-1:0]   dest_q;
    logic [S-1:0]   sel_dest;
    logic           load;
    logic           in_fire;

`ifdef N_STREAM_DEMUXER_RR_EN
    logic [S-1:0]   ptr_q;

    // S-bit wrap is exactly mod N_CH because N_CH is a power of two
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            ptr_q <= '0;
        end else if (in_fire && rr_mode) begin
            ptr_q <= ptr_q + 1'b1;
        end
    end

    assign sel_dest = rr_mode ? ptr_q : in_sel;
`else
    assign sel_dest = in_sel;
`endif

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            data_q <= '0;
            dest_q <= '0;
        end else if (load) begin
            data_q <= in_data;
            dest_q <= sel_dest;
        end
    end

    // in_ready depends only on state and the selected out_ready, never on in_valid
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = '0;
        load      = 1'b0;
        in_fire   = 1'b0;
        case (state_q)
            EMPTY: begin
                in_ready = reset_;
                in_fire  = in_valid && in_ready;
                if (in_fire) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                out_valid = {{(N_CH-1){1'b0}}, 1'b1} << dest_q;
                in_ready  = reset_ && out_ready[dest_q];
                in_fire   = in_valid && in_ready;
                if (in_fire) begin
                    load = 1'b1;
                end else if (out_ready[dest_q]) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign out_data = data_q;
    assign busy     = (state_q == FULL);

endmodule
